cpu_mem_loader: RTL and testbench

Host-side initiator for the cpu block's external memory ports: streams a program into instruction memory, runs the core for a programmed cycle count, then streams data memory out. It sits between the testbench/host word stream and the cpu ext ports (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext and the _2 set), and it owns the cpu's enable.

---
 rtl/cpu_loader_pkg.sv | 17 +
 rtl/loader_word_counter.sv | 39 +++
 rtl/cpu_mem_loader.sv | 189 ++++++++++++++++++
 tb/tb_cpu_mem_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_loader_pkg.sv
// Shared types for the cpu memory loader: FSM state encoding and the default
// byte-address stride between consecutive words.
package cpu_loader_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StRun  = 3'd2,
    StRd   = 3'd3,
    StWait = 3'd4,
    StOut  = 3'd5,
    StDone = 3'd6
  } state_e;

  localparam int unsigned AddrStepDefault = 4;

endpackage

// File: rtl/loader_word_counter.sv
// Loadable down-counter shared by the IMEM word, run-cycle and DMEM word counts.
// Saturates at zero; zero_o/one_o let the FSM see the final iteration early.
module loader_word_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o,
  output logic             one_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);
  assign one_o   = (count_q == CNT_W'(1));

endmodule

// File: rtl/cpu_mem_loader.sv
// Host-side initiator for the cpu ext memory ports: streams a program into IMEM,
// enables the core for a fixed cycle count, then dumps DMEM to the output stream.
module cpu_mem_loader
  import cpu_loader_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_STEP = AddrStepDefault,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic [CNT_W-1:0]  imem_words,
  input  logic [CNT_W-1:0]  dmem_words,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              cpu_enable,
  output logic [31:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic [31:0]       addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              busy,
  output logic              done
);

  localparam logic [31:0] AddrInc = 32'(ADDR_STEP);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic             cnt_load;
  logic             imem_dec, run_dec, dmem_dec;
  logic [CNT_W-1:0] imem_cnt, run_cnt, dmem_cnt;
  logic             imem_zero, imem_one;
  logic             run_zero, run_one;
  logic             dmem_zero, dmem_one;

  // All three counts are sampled together on an accepted start.
  loader_word_counter #(.CNT_W(CNT_W)) u_imem_cnt (
    .clk        (clk),
    .arst       (arst),
    .load_i     (cnt_load),
    .load_val_i (imem_words),
    .dec_i      (imem_dec),
    .count_o    (imem_cnt),
    .zero_o     (imem_zero),
    .one_o      (imem_one)
  );

  loader_word_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk        (clk),
    .arst       (arst),
    .load_i     (cnt_load),
    .load_val_i (run_cycles),
    .dec_i      (run_dec),
    .count_o    (run_cnt),
    .zero_o     (run_zero),
    .one_o      (run_one)
  );

  loader_word_counter #(.CNT_W(CNT_W)) u_dmem_cnt (
    .clk        (clk),
    .arst       (arst),
    .load_i     (cnt_load),
    .load_val_i (dmem_words),
    .dec_i      (dmem_dec),
    .count_o    (dmem_cnt),
    .zero_o     (dmem_zero),
    .one_o      (dmem_one)
  );

  // IMEM read data is never consumed; the port exists only for symmetry.
  logic unused_sig;
  assign unused_sig = ^{rdata_ext, imem_zero, run_one, imem_cnt, run_cnt, dmem_cnt};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    out_data_d = out_data_q;
    cnt_load   = 1'b0;
    imem_dec   = 1'b0;
    run_dec    = 1'b0;
    dmem_dec   = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    cpu_enable = 1'b0;
    addr_ext   = '0;
    wen_ext    = 1'b0;
    wdata_ext  = '0;
    addr_ext_2 = '0;
    ren_ext_2  = 1'b0;
    busy       = (state_q != StIdle);
    done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_load = 1'b1;
          addr_d   = '0;
          state_d  = (imem_words == '0) ? StRun : StLoad;
        end
      end

      StLoad: begin
        in_ready = 1'b1;
        // Write is combinational from the handshake so each word costs one cycle.
        if (in_valid) begin
          wen_ext   = 1'b1;
          addr_ext  = addr_q;
          wdata_ext = in_data;
          addr_d    = addr_q + AddrInc;
          imem_dec  = 1'b1;
          if (imem_one) begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (run_zero) begin
          addr_d  = '0;
          state_d = dmem_zero ? StDone : StRd;
        end else begin
          cpu_enable = 1'b1;
          run_dec    = 1'b1;
        end
      end

      StRd: begin
        ren_ext_2  = 1'b1;
        addr_ext_2 = addr_q;
        state_d    = StWait;
      end

      StWait: begin
        out_data_d = rdata_ext_2;
        state_d    = StOut;
      end

      StOut: begin
        out_valid = 1'b1;
        if (out_ready) begin
          addr_d   = addr_q + AddrInc;
          dmem_dec = 1'b1;
          state_d  = dmem_one ? StDone : StRd;
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data    = out_data_q;
  assign ren_ext     = 1'b0;
  assign wen_ext_2   = 1'b0;
  assign wdata_ext_2 = '0;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Scoreboard bench for cpu_mem_loader: a job driver queues expected IMEM writes,
// DMEM reads, dump words and enable counts; a negedge monitor pops and compares.
module tb_cpu_mem_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] imem_words = '0;
  logic [CW-1:0] dmem_words = '0;
  logic [CW-1:0] run_cycles = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          cpu_enable;
  logic [31:0]   addr_ext, addr_ext_2;
  logic          wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [DW-1:0] wdata_ext, wdata_ext_2;
  logic [DW-1:0] rdata_ext = 32'hDEAD_BEEF;
  logic [DW-1:0] rdata_ext_2 = '0;
  logic          busy, done;

  cpu_mem_loader dut (
    .clk         (clk),
    .arst        (arst),
    .start       (start),
    .imem_words  (imem_words),
    .dmem_words  (dmem_words),
    .run_cycles  (run_cycles),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .cpu_enable  (cpu_enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .rdata_ext   (rdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int stall_left = 0;
  bit slow_sink  = 1'b0;

  logic [63:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_out[$];
  int          exp_en[$];
  logic [31:0] prog_words[$];
  int          prog_gaps[$];
  logic [31:0] dmem[256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // DMEM model: registered read, data valid the cycle after ren_ext_2.
  always @(posedge clk) begin
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[9:2]];
  end

  // Sink: optional forced stall on each presented word, otherwise random or always ready.
  always @(posedge clk) begin
    #1;
    if (out_valid && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = slow_sink ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!arst) begin
      check("tieoffs", {30'b0, wen_ext_2, ren_ext, wdata_ext_2}, 64'd0);
      if (wen_ext || ren_ext_2) check("imem_dmem_exclusive", 64'(wen_ext & ren_ext_2), 64'd0);
      if (wen_ext) begin
        if (exp_wr.size() == 0) check("unexpected_wen", 64'(wen_ext), 64'd0);
        else begin
          e = exp_wr.pop_front();
          check("imem_addr", 64'(addr_ext), 64'(e[63:32]));
          check("imem_data", 64'(wdata_ext), 64'(e[31:0]));
        end
      end
      if (ren_ext_2) begin
        if (exp_rd.size() == 0) check("unexpected_ren", 64'(ren_ext_2), 64'd0);
        else check("dmem_addr", 64'(addr_ext_2), 64'(exp_rd.pop_front()));
      end
      if (out_valid) begin
        if (exp_out.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
        else begin
          check("out_data", 64'(out_data), 64'(exp_out[0]));
          if (out_ready) void'(exp_out.pop_front());
        end
      end
      if (cpu_enable) en_cnt++;
      if (done) begin
        if (exp_en.size() == 0) check("unexpected_done", 64'(done), 64'd0);
        else check("enable_cycles", 64'(en_cnt), 64'(exp_en.pop_front()));
        en_cnt = 0;
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input int gap);
    bit acc = 1'b0;
    int guard = 0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) check("in_ready_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // One full job; expectations come from the counts, prog_words and dmem.
  task automatic run_job(input int ni, input int nd, input int nr, input bit rand_dmem,
                         input bit inject, output int lat);
    int t0;
    int guard = 0;
    for (int i = 0; i < nd; i++) begin
      if (rand_dmem) dmem[i] = $urandom;
      exp_rd.push_back(32'(4 * i));
      exp_out.push_back(dmem[i]);
    end
    for (int i = 0; i < ni; i++) exp_wr.push_back({32'(4 * i), prog_words[i]});
    exp_en.push_back(nr);
    @(posedge clk); #1;
    start = 1'b1;
    imem_words = CW'(ni);
    dmem_words = CW'(nd);
    run_cycles = CW'(nr);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    imem_words = CW'($urandom_range(1, 9));
    dmem_words = CW'($urandom_range(1, 9));
    run_cycles = CW'($urandom_range(1, 9));
    for (int i = 0; i < ni; i++) send_word(prog_words[i], prog_gaps[i]);
    if (ni > 0) begin
      check("in_ready_in_run", 64'(in_ready), 64'd0);
      check("enable_on_run_entry", 64'(cpu_enable), 64'(nr != 0));
    end
    if (inject) begin
      start = 1'b1;
      imem_words = 7;
      dmem_words = 7;
      run_cycles = 7;
      @(posedge clk); #1;
      start = 1'b0;
    end
    do begin
      @(negedge clk);
      guard++;
    end while (!done && guard < 3000);
    if (!done) check("done_timeout", 64'(done), 64'd1);
    lat = cyc - t0;
    @(posedge clk); #1;
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_single_pulse", 64'(done), 64'd0);
    prog_words.delete();
    prog_gaps.delete();
  endtask

  initial begin
    int lat;
    int ni, nd, nr;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({in_ready, out_valid, cpu_enable, wen_ext, ren_ext_2, busy, done}),
          64'd0);
    check("rst_addr", 64'(addr_ext | addr_ext_2), 64'd0);
    check("rst_data", 64'(out_data | wdata_ext), 64'd0);
    arst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed: 3-word program with a gap, 10 run cycles, 2 dump words with a stalled sink.
    prog_words = '{32'h2008_0005, 32'h2009_0007, 32'h0109_5020};
    prog_gaps  = '{0, 1, 0};
    dmem[0] = 32'hA;
    dmem[1] = 32'hB;
    stall_left = 5;
    run_job(3, 2, 10, 1'b0, 1'b0, lat);

    // Zero run cycles: no enable at all.
    prog_words = '{32'h1111_2222, 32'h3333_4444};
    prog_gaps  = '{0, 0};
    run_job(2, 1, 0, 1'b1, 1'b0, lat);

    // No memory traffic, one enable cycle; done three cycles after start.
    run_job(0, 0, 1, 1'b1, 1'b0, lat);
    check("done_latency", 64'(lat), 64'd3);

    // Reset in LOAD after 2 of 4 words.
    for (int i = 0; i < 4; i++) exp_wr.push_back({32'(4 * i), 32'hC0DE_0000 + 32'(i)});
    @(posedge clk); #1;
    start = 1'b1;
    imem_words = 4;
    dmem_words = 2;
    run_cycles = 3;
    @(posedge clk); #1;
    start = 1'b0;
    send_word(32'hC0DE_0000, 0);
    send_word(32'hC0DE_0001, 0);
    in_valid = 1'b1;
    in_data  = 32'hC0DE_0002;
    #2;
    arst = 1'b1;
    #1;
    exp_wr.delete();
    exp_rd.delete();
    exp_out.delete();
    exp_en.delete();
    en_cnt = 0;
    check("abort_ctrl", 64'({in_ready, out_valid, cpu_enable, wen_ext, ren_ext_2, busy, done}),
          64'd0);
    check("abort_addr_data", 64'(addr_ext | addr_ext_2 | wdata_ext | out_data), 64'd0);
    @(posedge clk); #1;
    check("abort_next_cycle", 64'({in_ready, wen_ext, busy}), 64'd0);
    arst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_idle", 64'({wen_ext, busy}), 64'd0);
    end
    in_valid = 1'b0;

    // start while busy is ignored; counts are not re-sampled.
    prog_words = '{32'hAAAA_0001};
    prog_gaps  = '{0};
    run_job(1, 2, 8, 1'b1, 1'b1, lat);
    repeat (4) begin
      @(negedge clk);
      check("no_second_job", 64'(busy), 64'd0);
    end

    // Randomized jobs with irregular source and sink.
    slow_sink = 1'b1;
    for (int j = 0; j < 6; j++) begin
      ni = $urandom_range(0, 6);
      nd = $urandom_range(0, 5);
      nr = $urandom_range(0, 12);
      for (int i = 0; i < ni; i++) begin
        prog_words.push_back($urandom);
        prog_gaps.push_back($urandom_range(0, 2));
      end
      run_job(ni, nd, nr, 1'b1, 1'b0, lat);
    end

    repeat (3) @(posedge clk);
    check("leftover_expectations",
          64'(exp_wr.size() + exp_rd.size() + exp_out.size() + exp_en.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
